req_encoder_4x2: RTL and testbench
==================================

Name: req_encoder_4x2

Overview:
- Sequential counterpart to the team's combinational 2x4 decoder. It encodes 4 request lines back into a 2-bit index.
- Rising edges on the request lines are captured into pending flags.
- Pending requests are served in round-robin order and presented as a binary index on a valid/ready output handshake.
- It sits between the lab's input sources (buttons or decoder-driven lines) and any consumer of a 2-bit code, e.g. a display or register-select path.

Parameters:
- N, 4, number of request lines; only N=4 is required and verified.
- W, 2, index width (clog2(N)); derived, not overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- D  input  N  request lines; level inputs, already synchronous to clk.
- A  output  W  encoded index of the request being presented.
- valid  output  1  A holds a pending request.
- ready  input  1  consumer accepts A when valid && ready at a rising clk edge.
- pending  output  N  current pending flags.
- overrun  output  1  one-cycle pulse: a rising edge arrived on a line whose flag was already set.

Behaviour:
- Reset, synchronous, at a rising clk edge with rst=1:
  - pending <= 0; A <= 0; valid <= 0; overrun <= 0.
  - rr_ptr <= 0; FSM <= IDLE.
  - D_d <= D, so a line held high through reset is not an event.
- Edge capture, every non-reset cycle:
  - rise = D & ~D_d; then D_d <= D.
  - pending_next = (pending & ~clear_mask) | rise.
  - overrun <= |(rise & pending & ~clear_mask); the pulse lasts one cycle.
- Round-robin select: search pending starting at index rr_ptr, upward, wrapping 3 to 0; the first set bit wins.
- FSM states:
  - IDLE: if pending != 0, load A <= selected index, set valid <= 1, go to PRESENT. Otherwise stay, with valid = 0.
  - PRESENT:
    - A and valid are held stable while ready = 0. A must not change while valid is high.
    - On valid && ready: clear_mask = onehot(A), valid <= 0, rr_ptr <= A+1 (mod 4), go to IDLE.
- Throughput: one bubble cycle (IDLE) after every accept, so at most one accept per 2 cycles.
- Latency: D rises before edge k → pending bit set after edge k → valid=1 after edge k+1.
- Simultaneous new edge and accept on the same line: rise wins. The bit stays pending, the line is served again later, and overrun is not raised.
- Overrun: edges on an already-pending line are merged into the single pending flag and counted only via the overrun pulse.
- pending reflects registered flags. A bit stays set while that line is being presented and clears the cycle after the accept.
- Reset mid-PRESENT: valid drops after that edge and the request is lost. No handshake completes on the reset edge, even if ready=1.
- ready while valid=0 has no effect.

Decomposition:
- Shared package: constant N=4 and W=2; FSM state encoding IDLE=1'b0, PRESENT=1'b1.
- One sub-module, rr_select_4: combinational round-robin selector; inputs pending and rr_ptr, outputs idx and any.
- Edge capture, pending register and FSM stay in the top.

Test Plan:
1. Reset, then D=4'b0000 for 5 cycles → valid=0, A=0, pending=0, overrun never set.
2. D 0→4'b0100 before edge k, ready=1 → pending=4'b0100 after edge k, valid=1 with A=2 after k+1, accepted at k+2, pending=0 after k+3.
3. D 0→4'b1011 in one cycle, ready held 1, rr_ptr=0 → indices emitted in order 0,1,3, one every 2 cycles. Repeat with rr_ptr=2 → order 3,0,1.
4. D=4'b0010 pulsed twice while ready=0 → the second rise gives overrun=1 for exactly one cycle; valid stays 1 with A=1 unchanged for the whole stall; a single accept clears bit 1.
5. D[2] re-rises on the same edge as the accept of A=2 → pending[2] remains 1, A=2 is presented again after the bubble, overrun=0.
6. Assert rst for 1 cycle during PRESENT with D[3] held high → valid=0 and pending=0 after the reset edge, no event for D[3] until it falls and rises again.

Source files
------------

// File: rtl/req_encoder_4x2_pkg.sv
// Shared constants, FSM encoding and helpers for the 4-line request encoder.
package req_encoder_4x2_pkg;

   localparam int N = 4;
   localparam int W = 2;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   function automatic logic [N-1:0] onehot(input logic [W-1:0] idx);
      logic [N-1:0] mask;
      mask      = '0;
      mask[idx] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/req_encoder_4x2_if.sv
// Request/index handshake bundle; master drives requests and ready, slave is the encoder.
interface req_encoder_4x2_if;
   import req_encoder_4x2_pkg::*;

   logic [N-1:0] D;
   logic [W-1:0] A;
   logic         valid;
   logic         ready;
   logic [N-1:0] pending;
   logic         overrun;

   modport master (
      output D, ready,
      input  A, valid, pending, overrun
   );

   modport slave (
      input  D, ready,
      output A, valid, pending, overrun
   );

endinterface

// File: rtl/req_encoder_4x2_rr_select.sv
// Combinational round-robin pick: first set pending bit at or above rr_ptr, wrapping.
module rr_select_4
   import req_encoder_4x2_pkg::*;
(
   input  logic [N-1:0] pending,
   input  logic [W-1:0] rr_ptr,
   output logic [W-1:0] idx,
   output logic         any
);

   logic [W-1:0] cand [N];

   for (genvar g = 0; g < N; g++) begin : g_cand
      assign cand[g] = rr_ptr + W'(g);
   end

   // Scan from the farthest candidate down so the nearest one to rr_ptr is written last.
   always_comb begin
      idx = '0;
      any = 1'b0;
      for (int i = N-1; i >= 0; i--) begin
         if (pending[cand[i]]) begin
            idx = cand[i];
            any = 1'b1;
         end
      end
   end

endmodule

// File: rtl/req_encoder_4x2.sv
// Captures rising edges on 4 request lines and serves them round-robin as a 2-bit index.
module req_encoder_4x2
   import req_encoder_4x2_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   req_encoder_4x2_if.slave  bus
);

   state_t       state, state_next;
   logic [N-1:0] d_d;
   logic [N-1:0] pend_flags;
   logic [N-1:0] pend_next;
   logic [N-1:0] rise;
   logic [N-1:0] clear_mask;
   logic [W-1:0] a_reg, a_next;
   logic         valid_reg, valid_next;
   logic         overrun_reg;
   logic [W-1:0] rr_ptr, rr_next;
   logic [W-1:0] sel_idx;
   logic         sel_any;

   rr_select_4 u_sel (
      .pending (pend_flags),
      .rr_ptr  (rr_ptr),
      .idx     (sel_idx),
      .any     (sel_any)
   );

   assign rise      = bus.D & ~d_d;
   // A new rise on the line being accepted re-arms it, since it is OR'd after the clear.
   assign pend_next = (pend_flags & ~clear_mask) | rise;

   always_comb begin
      state_next = state;
      a_next     = a_reg;
      valid_next = valid_reg;
      rr_next    = rr_ptr;
      clear_mask = '0;
      case (state)
         IDLE: begin
            valid_next = 1'b0;
            if (sel_any) begin
               a_next     = sel_idx;
               valid_next = 1'b1;
               state_next = PRESENT;
            end
         end
         PRESENT: begin
            if (valid_reg && bus.ready) begin
               clear_mask = onehot(a_reg);
               valid_next = 1'b0;
               rr_next    = a_reg + W'(1);
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // Sampling D on reset keeps a line held high through reset from looking like an edge.
      d_d <= bus.D;
      if (rst) begin
         state       <= IDLE;
         pend_flags  <= '0;
         a_reg       <= '0;
         valid_reg   <= 1'b0;
         overrun_reg <= 1'b0;
         rr_ptr      <= '0;
      end else begin
         state       <= state_next;
         pend_flags  <= pend_next;
         a_reg       <= a_next;
         valid_reg   <= valid_next;
         overrun_reg <= |(rise & pend_flags & ~clear_mask);
         rr_ptr      <= rr_next;
      end
   end

   assign bus.A       = a_reg;
   assign bus.valid   = valid_reg;
   assign bus.pending = pend_flags;
   assign bus.overrun = overrun_reg;

endmodule

// File: tb/tb_req_encoder_4x2.sv
// Bench for req_encoder_4x2: directed scenarios plus random traffic against a behavioural model.
module tb_req_encoder_4x2;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   req_encoder_4x2_if bus();

   req_encoder_4x2 dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Behavioural model: request flags as plain bits, pointer and index as ints.
   bit m_pend [4];
   bit m_prev [4];
   int m_rr   = 0;
   bit m_busy = 0;
   int m_idx  = 0;
   bit m_ovr  = 0;

   always @(posedge clk) begin
      bit newp [4];
      bit ovr;
      int clr;
      bit found;
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_prev[i] = bus.D[i];
         end
         m_rr = 0; m_busy = 0; m_idx = 0; m_ovr = 0;
      end else begin
         clr = (m_busy && bus.ready) ? m_idx : -1;
         ovr = 0;
         for (int i = 0; i < 4; i++) begin
            bit r;
            r = bus.D[i] && !m_prev[i];
            if (r && m_pend[i] && i != clr) ovr = 1;
            newp[i] = (m_pend[i] && i != clr) || r;
         end
         if (m_busy) begin
            if (bus.ready) begin
               m_busy = 0;
               m_rr   = (m_idx + 1) % 4;
            end
         end else begin
            found = 0;
            for (int k = 0; k < 4; k++) begin
               if (!found && m_pend[(m_rr + k) % 4]) begin
                  found  = 1;
                  m_idx  = (m_rr + k) % 4;
                  m_busy = 1;
               end
            end
         end
         for (int i = 0; i < 4; i++) begin
            m_pend[i] = newp[i];
            m_prev[i] = bus.D[i];
         end
         m_ovr = ovr;
      end
   end

   function automatic logic [3:0] model_pend();
      logic [3:0] p;
      for (int i = 0; i < 4; i++) p[i] = m_pend[i];
      return p;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; bus.D = 4'b0000; bus.ready = 1'b0;
      tick();
      tick();
      n_checks++;
      if (bus.valid !== 1'b0 || bus.A !== 2'd0 || bus.pending !== 4'b0 || bus.overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: got valid=%b A=%0d pending=%b overrun=%b, expected 0/0/0000/0",
                  bus.valid, bus.A, bus.pending, bus.overrun);
      end
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         n_checks++;
         if (bus.valid !== 1'b0 || bus.A !== 2'd0 || bus.pending !== 4'b0 || bus.overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_quiet cycle %0d: got valid=%b A=%0d pending=%b overrun=%b, expected all zero",
                     c, bus.valid, bus.A, bus.pending, bus.overrun);
         end
      end
   endtask

   task automatic test_single();
      bus.D = 4'b0100; bus.ready = 1'b1;
      tick();
      n_checks++;
      if (bus.pending !== 4'b0100 || bus.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL single_capture: got pending=%b valid=%b, expected 0100 0", bus.pending, bus.valid);
      end
      tick();
      n_checks++;
      if (bus.valid !== 1'b1 || bus.A !== 2'd2) begin
         n_fail++;
         $display("FAIL single_present: got valid=%b A=%0d, expected 1 2", bus.valid, bus.A);
      end
      tick();
      n_checks++;
      if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_accept: got valid=%b pending=%b, expected 0 0000", bus.valid, bus.pending);
      end
      tick();
      n_checks++;
      if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL single_after: got valid=%b pending=%b, expected 0 0000", bus.valid, bus.pending);
      end
      bus.D = 4'b0000;
      tick();
   endtask

   // Issues 4'b1011 with ready held high and checks order and 2-cycle spacing of accepts.
   task automatic run_order(input int e0, input int e1, input int e2, input string tag);
      int got_idx [$];
      int got_cyc [$];
      int exp_idx [3];
      exp_idx = '{e0, e1, e2};
      bus.D = 4'b1011; bus.ready = 1'b1;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
            got_idx.push_back(int'(bus.A));
            got_cyc.push_back(c);
         end
      end
      n_checks++;
      if (got_idx.size() != 3) begin
         n_fail++;
         $display("FAIL %s_count: got %0d accepts, expected 3", tag, got_idx.size());
      end else begin
         for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (got_idx[k] != exp_idx[k]) begin
               n_fail++;
               $display("FAIL %s_idx%0d: got %0d expected %0d", tag, k, got_idx[k], exp_idx[k]);
            end
         end
         n_checks++;
         if (got_cyc[1] - got_cyc[0] != 2 || got_cyc[2] - got_cyc[1] != 2) begin
            n_fail++;
            $display("FAIL %s_spacing: got gaps %0d,%0d expected 2,2", tag,
                     got_cyc[1] - got_cyc[0], got_cyc[2] - got_cyc[1]);
         end
      end
      bus.D = 4'b0000;
      tick();
   endtask

   task automatic test_rr_order();
      rst = 1'b1; tick(); rst = 1'b0;
      run_order(0, 1, 3, "rr_from0");
      // Serving line 1 moves the pointer to 2.
      bus.D = 4'b0010; tick(); tick(); tick(); tick();
      bus.D = 4'b0000; tick();
      run_order(3, 0, 1, "rr_from2");
   endtask

   task automatic test_overrun();
      int ovr_cnt = 0;
      bit stall_bad = 0;
      bus.ready = 1'b0;
      bus.D = 4'b0010; tick();
      bus.D = 4'b0000; tick();
      bus.D = 4'b0010; tick();
      if (bus.overrun === 1'b1) ovr_cnt++;
      for (int c = 0; c < 5; c++) begin
         if (bus.valid !== 1'b1 || bus.A !== 2'd1) stall_bad = 1;
         tick();
         if (bus.overrun === 1'b1) ovr_cnt++;
      end
      n_checks++;
      if (ovr_cnt != 1) begin
         n_fail++;
         $display("FAIL overrun_pulse: got %0d cycles high, expected 1", ovr_cnt);
      end
      n_checks++;
      if (stall_bad || bus.valid !== 1'b1 || bus.A !== 2'd1) begin
         n_fail++;
         $display("FAIL overrun_stall: got valid=%b A=%0d (unstable=%0d), expected 1 1 0",
                  bus.valid, bus.A, stall_bad);
      end
      bus.ready = 1'b1; tick();
      n_checks++;
      if (bus.valid !== 1'b0 || bus.pending[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_accept: got valid=%b pending=%b, expected 0 and bit1 clear",
                  bus.valid, bus.pending);
      end
      bus.D = 4'b0000; tick(); tick();
   endtask

   task automatic test_rise_on_accept();
      bus.ready = 1'b0;
      bus.D = 4'b0100; tick();
      bus.D = 4'b0000; tick();
      bus.D = 4'b0100; bus.ready = 1'b1; tick();
      n_checks++;
      if (bus.pending[2] !== 1'b1 || bus.overrun !== 1'b0 || bus.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rise_accept_edge: got pending=%b overrun=%b valid=%b, expected bit2=1 0 0",
                  bus.pending, bus.overrun, bus.valid);
      end
      tick();
      n_checks++;
      if (bus.valid !== 1'b1 || bus.A !== 2'd2) begin
         n_fail++;
         $display("FAIL rise_accept_repr: got valid=%b A=%0d, expected 1 2", bus.valid, bus.A);
      end
      tick();
      n_checks++;
      if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL rise_accept_done: got valid=%b pending=%b, expected 0 0000", bus.valid, bus.pending);
      end
      bus.D = 4'b0000; tick();
   endtask

   task automatic test_reset_mid();
      bus.ready = 1'b0;
      bus.D = 4'b1000; tick(); tick();
      n_checks++;
      if (bus.valid !== 1'b1 || bus.A !== 2'd3) begin
         n_fail++;
         $display("FAIL rstmid_setup: got valid=%b A=%0d, expected 1 3", bus.valid, bus.A);
      end
      rst = 1'b1; bus.ready = 1'b1; tick();
      rst = 1'b0;
      n_checks++;
      if (bus.valid !== 1'b0 || bus.pending !== 4'b0000 || bus.overrun !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_drop: got valid=%b pending=%b overrun=%b, expected 0 0000 0",
                  bus.valid, bus.pending, bus.overrun);
      end
      tick(); tick(); tick();
      n_checks++;
      if (bus.valid !== 1'b0 || bus.pending !== 4'b0000) begin
         n_fail++;
         $display("FAIL rstmid_held: got valid=%b pending=%b, expected 0 0000", bus.valid, bus.pending);
      end
      bus.D = 4'b0000; tick();
      bus.D = 4'b1000; tick();
      n_checks++;
      if (bus.pending !== 4'b1000) begin
         n_fail++;
         $display("FAIL rstmid_rearm: got pending=%b expected 1000", bus.pending);
      end
      bus.D = 4'b0000; tick(); tick(); tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst       = ($urandom_range(0, 59) == 0);
         bus.D     = 4'($urandom);
         bus.ready = ($urandom_range(0, 2) != 0);
         tick();
         n_checks++;
         if (bus.valid !== m_busy || bus.A !== 2'(m_idx) || bus.pending !== model_pend()
             || bus.overrun !== m_ovr) begin
            n_fail++;
            $display("FAIL random cycle %0d: got valid=%b A=%0d pending=%b overrun=%b, expected %b %0d %b %b",
                     c, bus.valid, bus.A, bus.pending, bus.overrun, m_busy, m_idx, model_pend(), m_ovr);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; bus.D = 4'b0000; bus.ready = 1'b0;
      test_reset();
      test_single();
      test_rr_order();
      test_overrun();
      test_rise_on_accept();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
